// File: rtl/mod_reduce_seq.sv
// -----------------------------------------------------------------------------
// mod_reduce_seq
//   Sequential signed modular reducer. It takes a signed operand and an
//   unsigned modulus and returns the canonical residue in [0, p-1] together
//   with the floor quotient floor(in / p). The work is done by a restoring
//   divider that handles one bit per cycle, behind a start/done handshake.
//   A zero modulus is flagged through o_err and finishes in a single cycle.
//
// Parameters
//   IN_W : width of the signed operand and of the signed quotient (>= 2)
//   P_W  : width of the unsigned modulus and of the residue (P_W <= IN_W)
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst_n    : synchronous active-low reset
//   i_start  : request, sampled only while idle
//   i_in     : signed operand, captured when start is accepted
//   i_p      : unsigned modulus, captured when start is accepted
//   o_busy   : high while the divider or sign fix-up is running
//   o_done   : one-cycle pulse; o_res/o_q/o_err valid then and held after
//   o_res    : canonical residue, in mod p
//   o_q      : signed floor quotient
//   o_err    : divide-by-zero flag, updated with o_done
// -----------------------------------------------------------------------------
module mod_reduce_seq #(
  parameter int IN_W = 12,
  parameter int P_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [IN_W-1:0] i_in,
  input  logic [P_W-1:0]  i_p,
  output logic            o_busy,
  output logic            o_done,
  output logic [P_W-1:0]  o_res,
  output logic [IN_W-1:0] o_q,
  output logic            o_err
);

  localparam int                CNT_W    = $clog2(IN_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [IN_W-1:0]   r_mag;    // operand magnitude, shifted out MSB first; quotient fills in from the LSB
  logic [P_W:0]      r_rem;    // partial remainder, always < p between steps
  logic [P_W-1:0]    r_p;
  logic              r_sign;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [P_W-1:0]    r_res;
  logic [IN_W-1:0]   r_q;

  logic [IN_W-1:0]   w_in_mag;
  logic [P_W:0]      w_shift;
  logic [P_W:0]      w_p_ext;
  logic              w_ge;
  logic [P_W:0]      w_rem_step;
  logic [P_W-1:0]    w_res_neg;

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_in_mag   = i_in;
    w_shift    = '0;
    w_p_ext    = '0;
    w_ge       = 1'b0;
    w_rem_step = '0;
    w_res_neg  = '0;

    // Two's-complement magnitude; the most-negative value maps to 2^(IN_W-1),
    // which fits because the result is treated as unsigned.
    if (i_in[IN_W-1]) begin
      w_in_mag = ~i_in + IN_W'(1);
    end

    // Remainder is below p before the shift, so its top bit is always clear
    // and dropping it loses nothing.
    w_shift    = {r_rem[P_W-1:0], r_mag[IN_W-1]};
    w_p_ext    = {1'b0, r_p};
    w_ge       = (w_shift >= w_p_ext);
    w_rem_step = w_ge ? (w_shift - w_p_ext) : w_shift;

    // p - R with 0 < R < p, so the P_W-bit result is exact.
    w_res_neg  = P_W'(w_p_ext - r_rem);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register, regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_rem   <= '0;
      r_p     <= '0;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_res   <= '0;
      r_q     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            if (i_p == '0) begin
              // Zero modulus: report straight away without entering the divider.
              r_err   <= 1'b1;
              r_res   <= '0;
              r_q     <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_mag   <= w_in_mag;
              r_sign  <= i_in[IN_W-1];
              r_p     <= i_p;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_DIV;
            end
          end
        end

        S_DIV: begin
          r_rem <= w_rem_step;
          r_mag <= {r_mag[IN_W-2:0], w_ge};
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_FIX: begin
          // r_mag now holds the unsigned quotient of |in| / p.
          if (!r_sign) begin
            r_res <= r_rem[P_W-1:0];
            r_q   <= r_mag;
          end else if (r_rem == '0) begin
            r_res <= '0;
            r_q   <= ~r_mag + IN_W'(1);
          end else begin
            // Floor toward minus infinity: -(Q+1) is simply ~Q.
            r_res <= w_res_neg;
            r_q   <= ~r_mag;
          end
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          // Start is deliberately not looked at here.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_res  = r_res;
  assign o_q    = r_q;
  assign o_err  = r_err;

endmodule
